ifetch_mc: RTL and testbench
============================

Name: ifetch_mc

Overview:
- Instruction-fetch sequencer for the multi-cycle RV32I core.
- Sits between the program counter register and instruction memory. It reads the current PC, issues a handshaked read to imem, and latches the returned word into the instruction register for decode/execute.
- After execute signals completion, it issues the one-cycle PC write-enable that advances the PC register.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT for imem_rvalid before flagging an error; range 1..255.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_current  in  32  current PC from the PC register
- imem_req  out  1  read request valid
- imem_addr  out  32  read address; equals pc_current latched at request
- imem_ready  in  1  imem accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  instruction register
- instr_pc  out  32  PC of the held instruction
- exec_done  in  1  execute/writeback complete; PC's next-value input is final
- pc_we  out  1  write enable to the PC register, one-cycle pulse
- fetch_err  out  1  sticky error: misaligned PC or imem timeout

Behaviour:
- Async reset (rst_n=0): state=IDLE; imem_req=0, imem_addr=0, instr_valid=0, instr=NOP_INSTR, instr_pc=0, pc_we=0, fetch_err=0, timeout counter=0. Reset mid-transaction abandons it; a late rvalid is ignored unless the block is in WAIT.
- All outputs are registered.
- IDLE: one cycle after reset release, then REQ.
- REQ:
  - On entry, latch imem_addr=pc_current. If pc_current[1:0]!=0, go to ERR instead, with no request issued.
  - Otherwise imem_req=1, held with a stable address until imem_ready=1.
  - On imem_ready=1 with imem_rvalid=1 in the same cycle: capture data and go to HOLD (zero-wait memory).
  - On imem_ready=1 alone: go to WAIT.
  - rvalid without ready is ignored.
- WAIT:
  - imem_req=0; the counter increments each cycle.
  - On imem_rvalid=1: instr<=imem_rdata, instr_pc<=imem_addr, counter cleared, go to HOLD.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: go to ERR.
  - If rvalid arrives on the same cycle the count is reached, rvalid wins.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable.
  - On exec_done=1: go to UPDATE.
  - exec_done in any other state is ignored.
- UPDATE:
  - pc_we=1 for exactly this cycle; instr_valid=0, instr=NOP_INSTR.
  - Next state is REQ, which latches the updated pc_current.
- ERR:
  - fetch_err=1, imem_req=0, instr_valid=0, pc_we=0.
  - Terminal until rst_n asserts.
- Latency:
  - exec_done sampled at edge t gives pc_we high in cycle t+1, and imem_req with the new address in cycle t+2.
  - With zero-wait memory, request acceptance at edge t gives instr_valid high from cycle t+1.
- Exactly one imem request is outstanding at a time. pc_we is never asserted twice without an intervening fetch.

Test Plan:
- Zero-wait fetch:
  - Stimulus: reset, pc_current=0x00000000, imem_ready=1 and imem_rvalid=1 with rdata=0x00500093 in the request cycle.
  - Response: instr_valid=1, instr=0x00500093, instr_pc=0 the next cycle.
  - Then: exec_done pulse with pc_current=0x4 presented. Response: single pc_we pulse, then imem_req with imem_addr=0x4.
- Wait states:
  - Stimulus: imem_ready low for 3 cycles, then rvalid 5 cycles after acceptance, rdata=0xFE010113.
  - Response: imem_addr stable while req is high; instr_valid rises the cycle after rvalid; no pc_we before exec_done.
- Misaligned PC:
  - Stimulus: pc_current=0x00000006 at REQ.
  - Response: imem_req stays 0; fetch_err=1 the next cycle and stays 1; instr_valid=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, request accepted, no rvalid.
  - Response: fetch_err=1 after 4 WAIT cycles.
  - Variant: rvalid on the 4th cycle gives a normal HOLD with fetch_err=0.
- Spurious and misplaced inputs:
  - Stimulus: exec_done pulsed during REQ/WAIT; rvalid pulsed in REQ with ready=0.
  - Response: both ignored; no pc_we, instr unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT, then deliver a stale rvalid after release.
  - Response: all outputs at reset values immediately; the stale rvalid is ignored; a fresh fetch is issued from the current pc_current.

Source files
------------

// File: rtl/ifetch_mc.sv
// ifetch_mc: instruction-fetch sequencer for the multi-cycle RV32I core.
// Latches the PC and issues one handshaked imem read at a time. The returned
// word is held in the instruction register until execute completes. The block
// then pulses pc_we so the PC register advances.
module ifetch_mc #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_current,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        exec_done,
    output logic        pc_we,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        UPDATE,
        ERR
    } state_t;

    // The wait counter holds values 0..TIMEOUT_CYCLES-1.
    // A timeout fires on the cycle the counter would reach TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       pc_misaligned;

    // RV32I fetch addresses must be word aligned.
    assign pc_misaligned = |pc_current[1:0];

    // Fetch FSM; every output is a register updated here.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and the block order does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            pc_we       <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            // NOTE: pc_we defaults low every cycle, so one assignment in
            // HOLD produces a single-cycle pulse without an extra state.
            pc_we <= 1'b0;

            case (state)
                // Entering REQ from IDLE or UPDATE latches the PC.
                // A misaligned PC goes straight to ERR without a request.
                IDLE, UPDATE: begin
                    imem_addr <= pc_current;
                    if (pc_misaligned) begin
                        state     <= ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                // Hold the request with a stable address until it is
                // accepted. rvalid alone is ignored here.
                REQ: begin
                    if (imem_ready) begin
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                        if (imem_rvalid) begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                // Read data arriving on the timeout cycle still completes
                // the fetch, because rvalid is checked first.
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= HOLD;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        wait_cnt  <= '0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                // Keep the instruction stable until execute finishes.
                HOLD: begin
                    if (exec_done) begin
                        pc_we       <= 1'b1;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        state       <= UPDATE;
                    end
                end

                // Sticky error state; only reset leaves it.
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_mc.sv
// Directed testbench for ifetch_mc. Two instances share all inputs.
// "d" uses the default timeout, and "t" uses TIMEOUT_CYCLES=4.
module tb_ifetch_mc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_current;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        exec_done;

    logic        d_req, d_valid, d_pc_we, d_err;
    logic [31:0] d_addr, d_instr, d_instr_pc;
    logic        t_req, t_valid, t_pc_we, t_err;
    logic [31:0] t_addr, t_instr, t_instr_pc;

    int checks = 0;
    int errors = 0;

    ifetch_mc dut (
        .clk(clk), .rst_n(rst_n), .pc_current(pc_current),
        .imem_req(d_req), .imem_addr(d_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(d_valid), .instr(d_instr), .instr_pc(d_instr_pc),
        .exec_done(exec_done), .pc_we(d_pc_we), .fetch_err(d_err)
    );

    ifetch_mc #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk(clk), .rst_n(rst_n), .pc_current(pc_current),
        .imem_req(t_req), .imem_addr(t_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(t_valid), .instr(t_instr), .instr_pc(t_instr_pc),
        .exec_done(exec_done), .pc_we(t_pc_we), .fetch_err(t_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async reset applied between edges; released 3ns later with a new PC.
    task automatic do_reset(input logic [31:0] pc);
        rst_n = 1'b0;
        #3;
        pc_current = pc;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req"},      {31'd0, d_req},    32'd0);
        check({tag, " addr"},     d_addr,            32'd0);
        check({tag, " valid"},    {31'd0, d_valid},  32'd0);
        check({tag, " instr"},    d_instr,           NOP);
        check({tag, " instr_pc"}, d_instr_pc,        32'd0);
        check({tag, " pc_we"},    {31'd0, d_pc_we},  32'd0);
        check({tag, " err"},      {31'd0, d_err},    32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pc_current = 32'h0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
        #12;
        check_reset_values("por");
        rst_n = 1'b1;

        // ---- Zero-wait fetch ----
        step();                               // IDLE -> REQ
        check("zw req",  {31'd0, d_req}, 32'd1);
        check("zw addr", d_addr, 32'h0);
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();                               // accepted with data -> HOLD
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        check("zw valid",    {31'd0, d_valid}, 32'd1);
        check("zw instr",    d_instr, 32'h0050_0093);
        check("zw instr_pc", d_instr_pc, 32'h0);
        check("zw req drop", {31'd0, d_req}, 32'd0);
        pc_current = 32'h4; exec_done = 1'b1;
        step();                               // HOLD -> UPDATE
        exec_done = 1'b0;
        check("upd pc_we", {31'd0, d_pc_we}, 32'd1);
        check("upd valid", {31'd0, d_valid}, 32'd0);
        check("upd instr", d_instr, NOP);
        step();                               // UPDATE -> REQ at 0x4
        check("upd pc_we pulse", {31'd0, d_pc_we}, 32'd0);
        check("upd req",  {31'd0, d_req}, 32'd1);
        check("upd addr", d_addr, 32'h4);

        // ---- Wait states with misplaced exec_done / rvalid in REQ ----
        exec_done = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws req hold",  {31'd0, d_req}, 32'd1);
            check("ws addr hold", d_addr, 32'h4);
            check("ws no pc_we",  {31'd0, d_pc_we}, 32'd0);
            check("ws instr",     d_instr, NOP);
        end
        exec_done = 1'b0; imem_rvalid = 1'b0;
        imem_ready = 1'b1;
        step();                               // accepted -> WAIT
        imem_ready = 1'b0;
        check("ws req drop", {31'd0, d_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            exec_done = (i == 1);             // stray exec_done in WAIT
            step();
            check("ws wait valid", {31'd0, d_valid}, 32'd0);
            check("ws wait pc_we", {31'd0, d_pc_we}, 32'd0);
        end
        exec_done = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hFE01_0113;
        step();                               // rvalid 5 cycles after acceptance
        imem_rvalid = 1'b0;
        check("ws valid",    {31'd0, d_valid}, 32'd1);
        check("ws instr",    d_instr, 32'hFE01_0113);
        check("ws instr_pc", d_instr_pc, 32'h4);
        check("ws err",      {31'd0, d_err}, 32'd0);
        step();
        check("ws hold pc_we", {31'd0, d_pc_we}, 32'd0);
        check("ws hold valid", {31'd0, d_valid}, 32'd1);

        // ---- Reset in the middle of WAIT, then stale rvalid ----
        pc_current = 32'h8; exec_done = 1'b1;
        step();                               // UPDATE
        exec_done = 1'b0;
        step();                               // REQ at 0x8
        check("mr addr", d_addr, 32'h8);
        imem_ready = 1'b1;
        step();                               // WAIT
        imem_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid-rst");
        #2;
        pc_current = 32'h10; rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();                               // IDLE -> REQ, stale rvalid
        check("mr req",   {31'd0, d_req}, 32'd1);
        check("mr addr2", d_addr, 32'h10);
        check("mr valid", {31'd0, d_valid}, 32'd0);
        step();                               // still REQ, ready=0
        imem_rvalid = 1'b0;
        check("mr stale valid", {31'd0, d_valid}, 32'd0);
        check("mr stale instr", d_instr, NOP);

        // ---- Timeout on the TIMEOUT_CYCLES=4 instance ----
        imem_ready = 1'b1;
        step();                               // WAIT
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to early err", {31'd0, t_err}, 32'd0);
        end
        step();                               // 4th WAIT cycle, no rvalid
        check("to err",   {31'd0, t_err},   32'd1);
        check("to req",   {31'd0, t_req},   32'd0);
        check("to valid", {31'd0, t_valid}, 32'd0);
        check("to d err", {31'd0, d_err},   32'd0);
        step();
        check("to sticky", {31'd0, t_err}, 32'd1);

        // ---- rvalid on the 4th WAIT cycle wins over timeout ----
        do_reset(32'h20);
        step();                               // REQ
        imem_ready = 1'b1;
        step();                               // WAIT
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        check("tv valid",    {31'd0, t_valid}, 32'd1);
        check("tv err",      {31'd0, t_err},   32'd0);
        check("tv instr",    t_instr, 32'h1234_5678);
        check("tv instr_pc", t_instr_pc, 32'h20);

        // ---- Misaligned PC ----
        do_reset(32'h6);
        step();                               // IDLE -> ERR
        check("mis req",   {31'd0, d_req},   32'd0);
        check("mis err",   {31'd0, d_err},   32'd1);
        check("mis valid", {31'd0, d_valid}, 32'd0);
        imem_ready = 1'b1; imem_rvalid = 1'b1; exec_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("mis sticky", {31'd0, d_err},   32'd1);
            check("mis no req", {31'd0, d_req},   32'd0);
            check("mis pc_we",  {31'd0, d_pc_we}, 32'd0);
        end
        imem_ready = 1'b0; imem_rvalid = 1'b0; exec_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
